// File: rtl/visualizador_pkg.sv
// Shared definitions for the counter display slice.
// Holds the conversion FSM state type, the active-low seven-segment
// patterns ({g,f,e,d,c,b,a}, 0 = segment lit) and the blank pattern.
package visualizador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/decodificador_7seg.sv
// BCD nibble to active-low seven-segment decoder (purely combinational).
// Ports:
//   nibble : 4-bit BCD digit in
//   seg    : {g,f,e,d,c,b,a}, active-low; codes 10-15 decode to all-off
module decodificador_7seg
  import visualizador_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/visualizador_contador.sv
// Multiplexed decimal display of a free-running down counter.
// A double-dabble FSM repeatedly converts 'value' to BCD (period N+2 cycles)
// and a refresh scanner cycles through the digits driving an/seg.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | one cycle; next edge samples value, clears accumulator, cnt=N
// SHIFT | N cycles of add-3-then-shift on {accumulator, shift register}
// LATCH | one cycle; next edge publishes accumulator to bcd, pulses done
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   value      : binary value to display (N bits)
//   blank_lz   : 1 = blank leading zeros (units digit always shown)
//   seg        : registered active-low segments {g,f,e,d,c,b,a}
//   an         : registered active-low one-hot digit enable, bit 0 = units
//   bcd        : last completed conversion, nibble 0 = units
//   conv_done  : one-cycle pulse when bcd takes a new value
module visualizador_contador
  import visualizador_pkg::*;
#(
  parameter int N           = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          value,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  conv_done
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(N + 1);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  conv_state_t   state_q, state_d;
  logic [BW-1:0] acc_q, acc_d, acc_adj;
  logic [N-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bcd_d;
  logic          done_d;

  logic [RW-1:0] ref_q, ref_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [3:0]        nib_sel;
  logic              blank_sel;
  logic              lz_run;
  logic [DIGITS-1:0] blank_vec;
  logic [6:0]        dec_seg;
  logic [6:0]        seg_d;
  logic [DIGITS-1:0] an_d;

  // Add-3 correction applied to every nibble before each shift.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = SHIFT;
        sr_d    = value;
        acc_d   = '0;
        cnt_d   = CW'(N);
      end
      SHIFT: begin
        acc_d = {acc_adj[BW-2:0], sr_q[N-1]};
        sr_d  = sr_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1))
          state_d = LATCH;
      end
      LATCH: begin
        state_d = IDLE;
        bcd_d   = acc_q;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      sr_q      <= '0;
      cnt_q     <= '0;
      bcd       <= '0;
      conv_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      bcd       <= bcd_d;
      conv_done <= done_d;
    end
  end

  always_comb begin
    ref_d = ref_q + RW'(1);
    idx_d = idx_q;
    if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  // A digit is a leading zero when it and everything above it are zero.
  always_comb begin
    lz_run    = 1'b1;
    blank_vec = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_run       = lz_run & (bcd_d[4*i +: 4] == 4'd0);
      blank_vec[i] = lz_run & (i != 0);
    end
  end

  // Display works from next-cycle index and bcd so an, seg and bcd all
  // change on the same edge.
  always_comb begin
    nib_sel   = 4'd0;
    blank_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        nib_sel   = bcd_d[4*i +: 4];
        blank_sel = blank_vec[i];
      end
    end
  end

  decodificador_7seg u_dec (
    .nibble (nib_sel),
    .seg    (dec_seg)
  );

  always_comb begin
    seg_d = (blank_lz && blank_sel) ? SEG_BLANK : dec_seg;
    an_d  = ~(DIGITS'(1) << idx_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q <= '0;
      idx_q <= '0;
      an    <= ~DIGITS'(1);
      seg   <= SEG_0;
    end else begin
      ref_q <= ref_d;
      idx_q <= idx_d;
      an    <= an_d;
      seg   <= seg_d;
    end
  end

endmodule

// File: tb/tb_visualizador_contador.sv
module tb_visualizador_contador;

  logic        clk;
  logic        rst;
  logic [7:0]  value;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic [11:0] bcd;
  logic        conv_done;

  int check_cnt = 0;
  int pass_cnt  = 0;

  visualizador_contador #(.N(8), .DIGITS(3), .REFRESH_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .an        (an),
    .bcd       (bcd),
    .conv_done (conv_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] to_bcd(input int x);
    logic [3:0] h, t, u;
    h = 4'(x / 100);
    t = 4'((x / 10) % 10);
    u = 4'(x % 10);
    return {h, t, u};
  endfunction

  // Advances until conv_done is seen, bounded; a timeout is a failed check.
  task automatic wait_done();
    int n;
    n = 0;
    step();
    while (conv_done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check_cnt++;
    if (conv_done !== 1'b1) $display("FAIL wait_done: conv_done=%b required 1 within 20 cycles", conv_done);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; value = 8'd255; blank_lz = 1'b0;
    repeat (3) step();
    check_cnt++;
    if (bcd !== 12'h000) $display("FAIL reset_bcd: got %h required 000", bcd); else pass_cnt++;
    check_cnt++;
    if (conv_done !== 1'b0) $display("FAIL reset_done: got %b required 0", conv_done); else pass_cnt++;
    check_cnt++;
    if (an !== 3'b110) $display("FAIL reset_an: got %b required 110", an); else pass_cnt++;
    check_cnt++;
    if (seg !== 7'b1000000) $display("FAIL reset_seg: got %b required 1000000", seg); else pass_cnt++;
  endtask

  task automatic test_first_conversion();
    logic exp_done;
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step();
      exp_done = (c == 9 || c == 19 || c == 29);
      check_cnt++;
      if (conv_done !== exp_done)
        $display("FAIL first_conv_done c=%0d: got %b required %b", c, conv_done, exp_done);
      else pass_cnt++;
      if (c == 8) begin
        check_cnt++;
        if (bcd !== 12'h000) $display("FAIL first_conv_bcd_early: got %h required 000", bcd); else pass_cnt++;
      end
      if (c == 9) begin
        check_cnt++;
        if (bcd !== 12'h255) $display("FAIL first_conv_bcd: got %h required 255", bcd); else pass_cnt++;
      end
    end
  endtask

  task automatic test_blank();
    logic [6:0] exp_seg;
    value = 8'd0; blank_lz = 1'b1;
    wait_done();
    wait_done();
    check_cnt++;
    if (bcd !== 12'h000) $display("FAIL blank_bcd: got %h required 000", bcd); else pass_cnt++;
    for (int c = 0; c < 12; c++) begin
      step();
      exp_seg = (an == 3'b110) ? 7'b1000000 : 7'b1111111;
      check_cnt++;
      if (!(an == 3'b110 || an == 3'b101 || an == 3'b011))
        $display("FAIL blank_an c=%0d: got %b required one-hot-low", c, an);
      else if (seg !== exp_seg)
        $display("FAIL blank_seg c=%0d an=%b: got %b required %b", c, an, seg, exp_seg);
      else pass_cnt++;
    end
    blank_lz = 1'b0;
    step();
    for (int c = 0; c < 12; c++) begin
      step();
      check_cnt++;
      if (seg !== 7'b1000000) $display("FAIL noblank_seg c=%0d an=%b: got %b required 1000000", c, an, seg);
      else pass_cnt++;
    end
  endtask

  task automatic test_value_change();
    value = 8'd100;
    wait_done();
    step();            // sampling edge k takes 100
    step();            // edge k+1
    value = 8'd42;     // before edge k+2, mid-conversion
    wait_done();
    check_cnt++;
    if (bcd !== 12'h100) $display("FAIL change_first: got %h required 100", bcd); else pass_cnt++;
    wait_done();
    check_cnt++;
    if (bcd !== 12'h042) $display("FAIL change_second: got %h required 042", bcd); else pass_cnt++;
  endtask

  task automatic test_refresh();
    logic [2:0] exp_an [4];
    exp_an[0] = 3'b110; exp_an[1] = 3'b101; exp_an[2] = 3'b011; exp_an[3] = 3'b110;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_cnt++;
    if (an !== exp_an[0]) $display("FAIL refresh_an c=0: got %b required %b", an, exp_an[0]); else pass_cnt++;
    for (int c = 1; c < 16; c++) begin
      step();
      check_cnt++;
      if (an !== exp_an[c/4]) $display("FAIL refresh_an c=%0d: got %b required %b", c, an, exp_an[c/4]);
      else pass_cnt++;
    end
  endtask

  task automatic test_abort_and_sweep();
    int v, sampled;
    rst = 1'b1;
    step();
    rst = 1'b0; value = 8'd200;
    repeat (4) step();   // edges k..k+3
    rst = 1'b1;
    step();              // edge k+4 aborts
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      check_cnt++;
      if (conv_done !== 1'b0 || bcd !== 12'h000)
        $display("FAIL abort c=%0d: done=%b bcd=%h required done=0 bcd=000", c, conv_done, bcd);
      else pass_cnt++;
    end
    step();
    check_cnt++;
    if (conv_done !== 1'b1 || bcd !== 12'h200)
      $display("FAIL abort_restart: done=%b bcd=%h required done=1 bcd=200", conv_done, bcd);
    else pass_cnt++;
    // Now in IDLE: the next edge samples value. Sweep like the down counter.
    v = 255; value = 8'(v); sampled = v;
    for (int c = 0; c < 290; c++) begin
      step();
      if (v > 0) v--;
      value = 8'(v);
      if (conv_done === 1'b1) begin
        check_cnt++;
        if (bcd !== to_bcd(sampled))
          $display("FAIL sweep_bcd sampled=%0d: got %h required %h", sampled, bcd, to_bcd(sampled));
        else pass_cnt++;
        sampled = v;
      end
    end
  endtask

  initial begin
    rst = 1'b1; value = 8'd0; blank_lz = 1'b0;
    test_reset();
    test_first_conversion();
    test_blank();
    test_value_change();
    test_refresh();
    test_abort_and_sweep();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/visualizador_contador.md
VISUALIZADOR_CONTADOR -- requirements
Module: visualizador_contador

Interface
REQ-001 Parameter N, default 8, width of the binary input value (the count of the upstream N-bit down counter).
REQ-002 Parameter DIGITS, default 3, number of decimal digits displayed; shall satisfy 10**DIGITS > 2**N.
REQ-003 Parameter REFRESH_DIV, default 50000, clock cycles each digit stays enabled; minimum 1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 value  input  N  binary value to display, driven directly by the down counter output.
REQ-007 blank_lz  input  1  1 = blank leading zeros (digit 0 always shown).
REQ-008 seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-009 an  output  DIGITS  digit enables, active-low one-hot, registered; bit 0 = least significant digit.
REQ-010 bcd  output  4*DIGITS  last completed BCD conversion; nibble 0 = units.
REQ-011 conv_done  output  1  one-cycle pulse marking a new bcd value.

Function
REQ-012 The conversion FSM shall have states IDLE, SHIFT and LATCH, cycling IDLE(1 cycle) -> SHIFT(N cycles) -> LATCH(1 cycle) -> IDLE continuously while rst=0.
REQ-013 On the IDLE->SHIFT edge (edge k) the block shall sample value into an internal shift register, clear the BCD accumulator and load an iteration count of N.
REQ-014 Each SHIFT cycle shall add 3 to every accumulator nibble >= 5, then shift {accumulator, shift register} left by one bit (double dabble).
REQ-015 SHIFT shall exit to LATCH after exactly N shifts; no shift occurs in LATCH.
REQ-016 On the LATCH->IDLE edge (k+N+1) bcd shall load the accumulator and conv_done shall go high for exactly that one cycle; the conversion period is N+2 cycles.
REQ-017 Changes on value after edge k shall not affect the conversion in flight; they are captured at the next IDLE.
REQ-018 bcd shall change only on LATCH->IDLE edges, so the display never shows a partial conversion.
REQ-019 A refresh counter shall count 0..REFRESH_DIV-1 and wrap; on wrap the digit index shall advance by 1, wrapping from DIGITS-1 to 0.
REQ-020 an shall drive low only the bit of the current digit index; seg shall show the decoded nibble of bcd at that index, both registered and updated on the same edge.
REQ-021 Decoding shall use standard active-low patterns for 0-9 (0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000); nibbles 10-15 shall give 7'b1111111.
REQ-022 With blank_lz=1, a digit shall show 7'b1111111 when it and every more significant digit are zero; digit 0 is never blanked.
REQ-023 With blank_lz=0, all digits shall be shown including leading zeros.

Reset
REQ-024 While rst=1 at a rising edge: FSM = IDLE, accumulator/shift register/iteration count = 0, bcd = 0, conv_done = 0, refresh counter = 0, digit index = 0.
REQ-025 Output values after a reset edge: an = all ones except bit 0 low, seg = 7'b1000000.
REQ-026 Reset asserted mid-conversion shall abort it with no conv_done pulse; the first conversion starts at the first edge with rst=0.

Structure
REQ-027 A shared package visualizador_pkg shall hold the FSM state enum, the seven-segment pattern constants and the blank pattern constant.
REQ-028 The nibble-to-segment decode shall be one combinational sub-module, decodificador_7seg, instantiated once on the muxed nibble.

Verification (N=8, DIGITS=3, REFRESH_DIV=4)
REQ-029 rst=1 for 3 cycles with value=255 -> bcd=12'h000, conv_done=0, an=3'b110, seg=7'b1000000.
REQ-030 Release rst with value=255 held -> conv_done single pulse after edge k+9, bcd=12'h255; pulses repeat every 10 cycles.
REQ-031 value=0, blank_lz=1 -> bcd=12'h000; while an=3'b011 or 3'b101 seg=7'b1111111; while an=3'b110 seg=7'b1000000; with blank_lz=0 all three show 7'b1000000.
REQ-032 value changes 100 -> 42 two cycles after sampling edge -> that conversion gives bcd=12'h100, next gives 12'h042.
REQ-033 After reset, an sequence shall be 110,101,011,110, each held 4 cycles.
REQ-034 rst pulsed at edge k+4 of a conversion -> no conv_done, bcd=0; driving value from the down counter sweeping 255..0, every conv_done bcd equals the decimal value sampled.
